dp_ram_be: RTL and testbench

- Parametrised true dual-port RAM with per-byte write enables.
- Configurable read latency of 1 or 2 cycles, with a valid strobe per port.
- Selectable read-during-write mode and a defined write-write collision policy.
- Post-reset zero-clear sweep, so contents are known before use.
- Drop-in successor for shared scratch/weight buffers; both ports are usable by independent masters on one clock.

---
 rtl/dp_ram_pkg.sv | 17 +
 rtl/dp_ram_if.sv | 13 +
 rtl/dp_ram_rd_pipe.sv | 27 ++
 rtl/dp_ram_be.sv | 87 ++++++++
 tb/tb_dp_ram_be.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared constants, FSM encoding and byte-merge helper for dp_ram_be.
package dp_ram_pkg;
  localparam int RDW_READ_FIRST = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int MAX_W = 1024;
  localparam int MAX_B = MAX_W / 8;
  typedef logic [0:0] state_t;
  localparam state_t S_INIT = 1'b0;
  localparam state_t S_READY = 1'b1;
  // Callers narrower than MAX_W zero-extend in and truncate the result.
  function automatic logic [MAX_W-1:0] merge_be(input logic [MAX_W-1:0] old_w, new_w, input logic [MAX_B-1:0] be);
    logic [MAX_W-1:0] m;
    m = old_w;
    for (int k = 0; k < MAX_B; k++) m[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return m;
  endfunction
endpackage

// File: rtl/dp_ram_if.sv
// dp_ram_if: one RAM access port (request, byte enables, write data, read result).
interface dp_ram_if #(parameter int WIDTH = 32, parameter int HEIGHT = 48);
  localparam int BYTES = WIDTH / 8;
  localparam int ADDR_W = $clog2(HEIGHT);
  logic en;
  logic [BYTES-1:0] we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;
  logic valid;
  modport master(output en, we, addr, data, input q, valid);
  modport slave(input en, we, addr, data, output q, valid);
endinterface

// File: rtl/dp_ram_rd_pipe.sv
// dp_ram_rd_pipe: LAT-deep valid/data output stage; data only advances with valid so q holds between reads.
module dp_ram_rd_pipe #(parameter int WIDTH = 32, parameter int LAT = 1) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] q_o
);
  logic [LAT-1:0] v_q;
  logic [WIDTH-1:0] d_q [LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= v_i;
      if (v_i) d_q[0] <= d_i;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end
  assign v_o = v_q[LAT-1];
  assign q_o = d_q[LAT-1];
endmodule

// File: rtl/dp_ram_be.sv
// dp_ram_be: true dual-port byte-enable RAM with zero-clear sweep after reset.
// Define DP_RAM_COLLISION_CNT_EN to add a saturating collision_cnt output.
module dp_ram_be import dp_ram_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int HEIGHT = 48,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  dp_ram_if.slave a,
  dp_ram_if.slave b,
  output logic init_done,
  output logic collision
`ifdef DP_RAM_COLLISION_CNT_EN
  , output logic [15:0] collision_cnt
`endif
);
  localparam int BYTES = WIDTH / 8;
  localparam int ADDR_W = $clog2(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(HEIGHT - 1);
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("dp_ram_be: READ_LAT must be 1 or 2");
  end
  if (WIDTH % 8 != 0 || WIDTH > MAX_W || HEIGHT < 2) begin : g_bad_geom
    $error("dp_ram_be: WIDTH must be a multiple of 8 (<= MAX_W) and HEIGHT >= 2");
  end
  function automatic logic [WIDTH-1:0] mrg(input logic [WIDTH-1:0] o, n, input logic [BYTES-1:0] be);
    return WIDTH'(merge_be(MAX_W'(o), MAX_W'(n), MAX_B'(be)));
  endfunction
  logic [WIDTH-1:0] mem [HEIGHT];
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic init_done_q, coll_q, coll_d, in_a, in_b;
  logic [BYTES-1:0] wa, wb;
  logic [WIDTH-1:0] old_a, old_b, rd_a, rd_b;
  always_comb begin
    state_d = (state_q == S_INIT && cnt_q == LAST) ? S_READY : state_q;
    cnt_d = (state_q == S_INIT && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
    in_a = 32'(a.addr) < HEIGHT;
    in_b = 32'(b.addr) < HEIGHT;
    wa = (init_done_q && a.en && in_a) ? a.we : '0;
    wb = (init_done_q && b.en && in_b) ? b.we : '0;
    old_a = in_a ? mem[a.addr] : '0;
    old_b = in_b ? mem[b.addr] : '0;
    // B merged first so A's bytes win, matching the write ordering below.
    rd_a = RDW_MODE == RDW_WRITE_FIRST ? mrg(mrg(old_a, b.data, a.addr == b.addr ? wb : '0), a.data, wa) : old_a;
    rd_b = RDW_MODE == RDW_WRITE_FIRST ? mrg(mrg(old_b, b.data, wb), a.data, a.addr == b.addr ? wa : '0) : old_b;
    coll_d = a.addr == b.addr && |(wa & wb);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q <= '0;
      init_done_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_done_q <= state_q == S_READY;
      coll_q <= coll_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) mem[cnt_q] <= '0;
    for (int k = 0; k < BYTES; k++) begin
      if (wb[k]) mem[b.addr][8*k +: 8] <= b.data[8*k +: 8];
      if (wa[k]) mem[a.addr][8*k +: 8] <= a.data[8*k +: 8];
    end
  end
  dp_ram_rd_pipe #(.WIDTH(WIDTH), .LAT(READ_LAT)) u_pipe_a (
    .clk(clk), .rst(rst), .v_i(init_done_q && a.en), .d_i(rd_a), .v_o(a.valid), .q_o(a.q)
  );
  dp_ram_rd_pipe #(.WIDTH(WIDTH), .LAT(READ_LAT)) u_pipe_b (
    .clk(clk), .rst(rst), .v_i(init_done_q && b.en), .d_i(rd_b), .v_o(b.valid), .q_o(b.q)
  );
  assign init_done = init_done_q;
  assign collision = coll_q;
`ifdef DP_RAM_COLLISION_CNT_EN
  logic [15:0] ccnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ccnt_q <= '0;
    else if (coll_d && ccnt_q != 16'hFFFF) ccnt_q <= ccnt_q + 16'd1;
  end
  assign collision_cnt = ccnt_q;
`endif
endmodule

// File: tb/tb_dp_ram_be.sv
// tb_dp_ram_be: two instances (lat1/read-first and lat2/write-first) driven by identical directed vectors.
module tb_dp_ram_be;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic en_a, en_b;
  logic [3:0] we_a, we_b;
  logic [5:0] addr_a, addr_b;
  logic [31:0] data_a, data_b;
  dp_ram_if #(.WIDTH(32), .HEIGHT(48)) a0(), b0(), a1(), b1();
  assign {a0.en, a0.we, a0.addr, a0.data} = {en_a, we_a, addr_a, data_a};
  assign {a1.en, a1.we, a1.addr, a1.data} = {en_a, we_a, addr_a, data_a};
  assign {b0.en, b0.we, b0.addr, b0.data} = {en_b, we_b, addr_b, data_b};
  assign {b1.en, b1.we, b1.addr, b1.data} = {en_b, we_b, addr_b, data_b};
  logic done0, done1, col0, col1;
`ifdef DP_RAM_COLLISION_CNT_EN
  logic [15:0] cc0, cc1;
`endif
  dp_ram_be #(.WIDTH(32), .HEIGHT(48), .READ_LAT(1), .RDW_MODE(0)) d0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .init_done(done0), .collision(col0)
`ifdef DP_RAM_COLLISION_CNT_EN
    , .collision_cnt(cc0)
`endif
  );
  dp_ram_be #(.WIDTH(32), .HEIGHT(48), .READ_LAT(2), .RDW_MODE(1)) d1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .init_done(done1), .collision(col1)
`ifdef DP_RAM_COLLISION_CNT_EN
    , .collision_cnt(cc1)
`endif
  );
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic v0a, v0b, v1a, v1b, c0, c1, c0n, c1n, seen;
  logic [31:0] val [4];
  int cyc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // One-cycle request, then captures lat-1 results (d0) and lat-2 results (d1).
  task automatic req(input logic ea, input logic [3:0] wea, input logic [5:0] aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] web, input logic [5:0] ab, input logic [31:0] db);
    {en_a, we_a, addr_a, data_a, en_b, we_b, addr_b, data_b} = {ea, wea, aa, da, eb, web, ab, db};
    step();
    en_a = 1'b0;
    en_b = 1'b0;
    {r0a, v0a, r0b, v0b, c0, c1} = {a0.q, a0.valid, b0.q, b0.valid, col0, col1};
    step();
    {r1a, v1a, r1b, v1b, c0n, c1n} = {a1.q, a1.valid, b1.q, b1.valid, col0, col1};
  endtask
  task automatic count_sweep(output int n);
    n = 0;
    while (!done0 && n < 200) begin
      step();
      n++;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    {en_a, en_b, we_a, we_b, addr_a, addr_b, data_a, data_b} = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_q", a0.q | b1.q, 0);
    check("rst_valid", 32'(a0.valid | b1.valid), 0);
    check("rst_done", 32'(done0 | done1), 0);
    check("rst_col", 32'(col0 | col1), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    en_a = 1'b1;
    addr_a = 6'd0;
    seen = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 200) begin
      step();
      cyc++;
      seen |= a0.valid | a1.valid;
    end
    en_a = 1'b0;
    step();
    seen |= a0.valid | a1.valid;
    check("sweep_cycles", cyc, 49);
    check("sweep_done1", 32'(done1), 1);
    check("sweep_no_valid", 32'(seen), 0);
    for (int i = 0; i < 48; i++) begin
      en_a = 1'b1;
      addr_a = 6'(i);
      step();
      check("sweep_rd_v0", 32'(a0.valid), 1);
      check("sweep_rd_q0", a0.q, 0);
      if (i > 0) check("sweep_rd_v1", 32'(a1.valid), 1);
      if (i > 0) check("sweep_rd_q1", a1.q, 0);
    end
    en_a = 1'b0;
    step();
    req(1'b1, 4'hF, 6'd5, 32'h11223344, 1'b0, 4'h0, 6'd0, 32'h0);
    check("bw1_rf", r0a, 32'h0);
    check("bw1_wf", r1a, 32'h11223344);
    req(1'b1, 4'b0101, 6'd5, 32'hAABBCCDD, 1'b0, 4'h0, 6'd0, 32'h0);
    check("bw2_rf", r0a, 32'h11223344);
    check("bw2_wf", r1a, 32'h11BB33DD);
    req(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd5, 32'h0);
    check("bw_rd0", r0b, 32'h11BB33DD);
    check("bw_v0", 32'(v0b), 1);
    check("bw_rd1", r1b, 32'h11BB33DD);
    check("bw_v1", 32'(v1b), 1);
    req(1'b1, 4'hF, 6'd7, 32'h1, 1'b0, 4'h0, 6'd0, 32'h0);
    req(1'b1, 4'hF, 6'd7, 32'h2, 1'b1, 4'h0, 6'd7, 32'h0);
    check("rdw_rf", r0b, 32'h1);
    check("rdw_wf", r1b, 32'h2);
    req(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd7, 32'h0);
    check("rdw_after", r0b, 32'h2);
    req(1'b1, 4'b1100, 6'd3, 32'hFFFF0000, 1'b1, 4'b0110, 6'd3, 32'h0000EEEE);
    check("col_pulse0", 32'(c0), 1);
    check("col_pulse1", 32'(c1), 1);
    check("col_end0", 32'(c0n), 0);
    check("col_rf", r0a, 32'h0);
    check("col_wf_a", r1a, 32'hFFFFEE00);
    check("col_wf_b", r1b, 32'hFFFFEE00);
`ifdef DP_RAM_COLLISION_CNT_EN
    check("col_cnt0", 32'(cc0), 1);
    check("col_cnt1", 32'(cc1), 1);
`endif
    req(1'b1, 4'h0, 6'd3, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    check("col_mem", r0a, 32'hFFFFEE00);
    check("col_idle", 32'(c0), 0);
    req(1'b1, 4'b0011, 6'd4, 32'h12345678, 1'b1, 4'b1100, 6'd4, 32'h9ABCDEF0);
    check("nocol_mask", 32'(c0), 0);
    check("nocol_wf", r1a, 32'h9ABC5678);
    req(1'b1, 4'hF, 6'd10, 32'h1, 1'b1, 4'hF, 6'd11, 32'h2);
    check("nocol_addr", 32'(c0 | c1), 0);
    req(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd4, 32'h0);
    check("nocol_mem", r0b, 32'h9ABC5678);
    req(1'b1, 4'hF, 6'd50, 32'hDEADBEEF, 1'b0, 4'h0, 6'd0, 32'h0);
    check("oor_wf", r1a, 32'h0);
    req(1'b1, 4'h0, 6'd50, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    check("oor_rd", r0a, 32'h0);
    check("oor_v", 32'(v0a), 1);
    req(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'hF, 6'd47, 32'h5A5A5A5A);
    req(1'b1, 4'h0, 6'd47, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    check("last_rd0", r0a, 32'h5A5A5A5A);
    check("last_rd1", r1a, 32'h5A5A5A5A);
    for (int i = 0; i < 4; i++) begin
      val[i] = 32'hC0DE0000 | 32'(i + 1);
      req(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'hF, 6'(i), val[i]);
    end
    for (int s = 1; s <= 6; s++) begin
      en_a = s <= 4;
      addr_a = 6'(s - 1);
      step();
      check("tp_v0", 32'(a0.valid), 32'(s <= 4));
      if (s <= 4) check("tp_q0", a0.q, val[s-1]);
      check("tp_v1", 32'(a1.valid), 32'(s >= 2 && s <= 5));
      if (s >= 2 && s <= 5) check("tp_q1", a1.q, val[s-2]);
    end
    en_a = 1'b0;
    check("hold_q1", a1.q, val[3]);
    rst = 1'b1;
    #1;
    check("rst2_q", a0.q | a1.q | b0.q | b1.q, 0);
    check("rst2_done", 32'(done0 | done1), 0);
    step();
    rst = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    #1;
    check("mid_rst_done", 32'(done0), 0);
`ifdef DP_RAM_COLLISION_CNT_EN
    check("mid_rst_cnt", 32'(cc0), 0);
`endif
    repeat (2) step();
    rst = 1'b0;
    count_sweep(cyc);
    check("mid_sweep_cycles", cyc, 49);
    req(1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 4'h0, 6'd3, 32'h0);
    check("mid_clear_a", r0a, 32'h0);
    check("mid_clear_b", r1b, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
